// File: rtl/qsfp_link_monitor_pkg.sv
// ---------------------------------------------------------------------------
// qsfp_mon_pkg
// Shared definitions for the QSFP link monitor: the link FSM state encoding,
// the width of the up-time counter, and a saturating increment helper used
// by every statistics counter in the block.
// ---------------------------------------------------------------------------
package qsfp_mon_pkg;

  typedef enum logic [1:0] {
    DOWN      = 2'd0,
    QUAL_UP   = 2'd1,
    UP        = 2'd2,
    QUAL_DOWN = 2'd3
  } linkState_e;

  localparam int UP_CYCLES_W = 32;

  // Increments value unless it already sits at the all-ones value of a
  // counter that is 'width' bits wide (width 1..32); callers cast the
  // result back down to their own counter width.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/qsfp_link_monitor_if.sv
// ---------------------------------------------------------------------------
// qsfp_link_monitor_if
// Bundles the per-channel signals of the QSFP link monitor.
//   channel_up_async : raw channel-up from the transceiver core (any domain)
//   clear_stats      : single-cycle pulse clearing the statistics
//   channel_up       : debounced link-up level
//   link_up_pulse    : one-cycle pulse on an accepted rising transition
//   link_down_pulse  : one-cycle pulse on an accepted falling transition
//   drop_count       : saturating count of accepted up->down transitions
//   flap_count       : saturating count of aborted qualifications
//   up_cycles        : saturating cycles since the last accepted link-up
// Modports: master drives the inputs and reads the status (transceiver /
// status-register side); slave is the monitor itself.
// ---------------------------------------------------------------------------
interface qsfp_link_monitor_if #(
  parameter int CNT_W = 16
);
  import qsfp_mon_pkg::*;

  logic                   channel_up_async;
  logic                   clear_stats;
  logic                   channel_up;
  logic                   link_up_pulse;
  logic                   link_down_pulse;
  logic [CNT_W-1:0]       drop_count;
  logic [CNT_W-1:0]       flap_count;
  logic [UP_CYCLES_W-1:0] up_cycles;

  modport master (
    output channel_up_async,
    output clear_stats,
    input  channel_up,
    input  link_up_pulse,
    input  link_down_pulse,
    input  drop_count,
    input  flap_count,
    input  up_cycles
  );

  modport slave (
    input  channel_up_async,
    input  clear_stats,
    output channel_up,
    output link_up_pulse,
    output link_down_pulse,
    output drop_count,
    output flap_count,
    output up_cycles
  );

endinterface

// File: rtl/qsfp_link_monitor_sync.sv
// ---------------------------------------------------------------------------
// link_mon_sync
// Multi-flop synchronizer bringing the raw channel-up level into axi_clk.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, clears every stage
//   i_async : asynchronous input level
//   o_sync  : synchronized level (last stage of the chain)
// ---------------------------------------------------------------------------
module link_mon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/qsfp_link_monitor.sv
// ---------------------------------------------------------------------------
// qsfp_link_monitor
// Per-channel QSFP link monitor. Synchronizes the raw channel-up indication,
// debounces it through a four-state qualification FSM and keeps link-event
// statistics. Every output is a flop in axi_clk, so the status register
// block can sample them directly.
//   axi_clk    : only clock
//   axi_resetn : asynchronous active-low reset
//   mon        : qsfp_link_monitor_if.slave (inputs channel_up_async,
//                clear_stats; status outputs channel_up, link_up_pulse,
//                link_down_pulse, drop_count, flap_count, up_cycles)
// Parameters: SYNC_STAGES (2..4), DEBOUNCE_CYCLES (>= 1), CNT_W (1..32).
// Build option: define QSFP_LINK_MON_FLAP_COUNT_EN to count aborted
// qualifications in flap_count; otherwise flap_count reads 0.
// ---------------------------------------------------------------------------
module qsfp_link_monitor
  import qsfp_mon_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic                axi_clk,
  input  logic                axi_resetn,
  qsfp_link_monitor_if.slave  mon
);

  localparam int                DCNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);

  logic                   w_sUp;
  linkState_e             r_state;
  linkState_e             w_nextState;
  logic [DCNT_W-1:0]      r_dcnt;
  logic [DCNT_W-1:0]      w_nextDcnt;
  logic                   w_upEvent;
  logic                   w_downEvent;
  logic                   r_channelUp;
  logic                   r_linkUpPulse;
  logic                   r_linkDownPulse;
  logic [CNT_W-1:0]       r_dropCount;
  logic [UP_CYCLES_W-1:0] r_upCycles;

  link_mon_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (axi_clk),
    .rst_n   (axi_resetn),
    .i_async (mon.channel_up_async),
    .o_sync  (w_sUp)
  );

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= DOWN;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_dcnt  <= w_nextDcnt;
    end
  end

  // dcnt counts cycles already spent in a qualifying state, starting at 1 on
  // entry, so the qualifying state lasts exactly DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_nextState = r_state;
    w_nextDcnt  = r_dcnt;
    w_upEvent   = 1'b0;
    w_downEvent = 1'b0;
    case (r_state)
      DOWN: begin
        if (w_sUp) begin
          w_nextState = QUAL_UP;
          w_nextDcnt  = DCNT_ONE;
        end
      end
      QUAL_UP: begin
        if (!w_sUp) begin
          w_nextState = DOWN;
        end else if (r_dcnt == DCNT_MAX) begin
          w_nextState = UP;
          w_upEvent   = 1'b1;
        end else begin
          w_nextDcnt = r_dcnt + 1'b1;
        end
      end
      UP: begin
        if (!w_sUp) begin
          w_nextState = QUAL_DOWN;
          w_nextDcnt  = DCNT_ONE;
        end
      end
      QUAL_DOWN: begin
        if (w_sUp) begin
          w_nextState = UP;
        end else if (r_dcnt == DCNT_MAX) begin
          w_nextState = DOWN;
          w_downEvent = 1'b1;
        end else begin
          w_nextDcnt = r_dcnt + 1'b1;
        end
      end
      default: begin
        w_nextState = DOWN;
      end
    endcase
  end

  // Level and pulses are registered from the next state, so the pulses land
  // in the same cycle the level changes.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_channelUp     <= 1'b0;
      r_linkUpPulse   <= 1'b0;
      r_linkDownPulse <= 1'b0;
    end else begin
      r_channelUp     <= (w_nextState == UP) || (w_nextState == QUAL_DOWN);
      r_linkUpPulse   <= w_upEvent;
      r_linkDownPulse <= w_downEvent;
    end
  end

  // clear_stats has priority over any increment or reload in the same cycle.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_dropCount <= '0;
      r_upCycles  <= '0;
    end else if (mon.clear_stats) begin
      r_dropCount <= '0;
      r_upCycles  <= '0;
    end else begin
      if (w_downEvent) begin
        r_dropCount <= CNT_W'(satInc(32'(r_dropCount), CNT_W));
      end
      if (w_upEvent) begin
        r_upCycles <= '0;
      end else if (r_channelUp) begin
        r_upCycles <= satInc(r_upCycles, UP_CYCLES_W);
      end
    end
  end

`ifdef QSFP_LINK_MON_FLAP_COUNT_EN
  logic             w_flapEvent;
  logic [CNT_W-1:0] r_flapCount;

  // A flap is a qualification abandoned because the input reverted.
  assign w_flapEvent = ((r_state == QUAL_UP)   && !w_sUp) ||
                       ((r_state == QUAL_DOWN) &&  w_sUp);

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_flapCount <= '0;
    end else if (mon.clear_stats) begin
      r_flapCount <= '0;
    end else if (w_flapEvent) begin
      r_flapCount <= CNT_W'(satInc(32'(r_flapCount), CNT_W));
    end
  end

  assign mon.flap_count = r_flapCount;
`else
  assign mon.flap_count = '0;
`endif

  assign mon.channel_up      = r_channelUp;
  assign mon.link_up_pulse   = r_linkUpPulse;
  assign mon.link_down_pulse = r_linkDownPulse;
  assign mon.drop_count      = r_dropCount;
  assign mon.up_cycles       = r_upCycles;

endmodule

// File: tb/tb_qsfp_link_monitor.sv
// ---------------------------------------------------------------------------
// tb_qsfp_link_monitor
// Directed bench for qsfp_link_monitor. Three instances share one input
// stream: the main one (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, CNT_W=16), a
// narrow-counter one (CNT_W=2) and a fast one (DEBOUNCE_CYCLES=1). The main
// instance alone receives clear_stats. Step n means the n-th rising clock
// edge after an input change; outputs are sampled 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_qsfp_link_monitor;

  logic clk;
  logic rstN;
  logic tbUp;
  logic tbClear;

  int errorCount = 0;
  int checkCount = 0;
  int upPulses;
  int downPulses;
  logic [31:0] expFlap;
  logic [31:0] expDrop;
  logic [31:0] expSatDrop;
  logic [31:0] expUpLow;

  qsfp_link_monitor_if #(.CNT_W(16)) ifMain ();
  qsfp_link_monitor_if #(.CNT_W(2))  ifSat ();
  qsfp_link_monitor_if #(.CNT_W(16)) ifFast ();

  assign ifMain.channel_up_async = tbUp;
  assign ifMain.clear_stats      = tbClear;
  assign ifSat.channel_up_async  = tbUp;
  assign ifSat.clear_stats       = 1'b0;
  assign ifFast.channel_up_async = tbUp;
  assign ifFast.clear_stats      = 1'b0;

  qsfp_link_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(16)) dutMain (
    .axi_clk    (clk),
    .axi_resetn (rstN),
    .mon        (ifMain)
  );

  qsfp_link_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(2)) dutSat (
    .axi_clk    (clk),
    .axi_resetn (rstN),
    .mon        (ifSat)
  );

  qsfp_link_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dutFast (
    .axi_clk    (clk),
    .axi_resetn (rstN),
    .mon        (ifFast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic up, input logic clr);
    tbUp    = up;
    tbClear = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic countPulses();
    if (ifMain.link_up_pulse === 1'b1)   upPulses++;
    if (ifMain.link_down_pulse === 1'b1) downPulses++;
  endtask

  initial begin
`ifdef QSFP_LINK_MON_FLAP_COUNT_EN
    expFlap = 32'd1;
`else
    expFlap = 32'd0;
`endif
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #2 rstN = 1'b0;
    repeat (3) stepCycle();

    // Reset state
    checkOutput("rst_channel_up", 32'(ifMain.channel_up), 32'd0);
    checkOutput("rst_up_pulse", 32'(ifMain.link_up_pulse), 32'd0);
    checkOutput("rst_down_pulse", 32'(ifMain.link_down_pulse), 32'd0);
    checkOutput("rst_drop_count", 32'(ifMain.drop_count), 32'd0);
    checkOutput("rst_flap_count", 32'(ifMain.flap_count), 32'd0);
    checkOutput("rst_up_cycles", ifMain.up_cycles, 32'd0);
    rstN = 1'b1;

    // First link-up: channel_up at step 11 (main), step 4 (fast)
    applyStimulus(1'b1, 1'b0);
    for (int s = 1; s <= 13; s++) begin
      stepCycle();
      if (s == 3) checkOutput("fast_up_early", 32'(ifFast.channel_up), 32'd0);
      if (s == 4) begin
        checkOutput("fast_up", 32'(ifFast.channel_up), 32'd1);
        checkOutput("fast_up_pulse", 32'(ifFast.link_up_pulse), 32'd1);
      end
      if (s == 10) begin
        checkOutput("rise_early", 32'(ifMain.channel_up), 32'd0);
        checkOutput("rise_pulse_early", 32'(ifMain.link_up_pulse), 32'd0);
      end
      if (s == 11) begin
        checkOutput("rise_level", 32'(ifMain.channel_up), 32'd1);
        checkOutput("rise_pulse", 32'(ifMain.link_up_pulse), 32'd1);
        checkOutput("rise_up_cycles", ifMain.up_cycles, 32'd0);
      end
      if (s == 12) begin
        checkOutput("rise_pulse_end", 32'(ifMain.link_up_pulse), 32'd0);
        checkOutput("up_cycles_1", ifMain.up_cycles, 32'd1);
      end
      if (s == 13) checkOutput("up_cycles_2", ifMain.up_cycles, 32'd2);
    end

    // Short 5-cycle glitch low: aborted qualification
    upPulses = 0;
    downPulses = 0;
    applyStimulus(1'b0, 1'b0);
    for (int s = 1; s <= 15; s++) begin
      stepCycle();
      if (s == 5) applyStimulus(1'b1, 1'b0);
      countPulses();
      checkOutput("flap_level", 32'(ifMain.channel_up), 32'd1);
    end
    checkOutput("flap_up_pulses", 32'(upPulses), 32'd0);
    checkOutput("flap_down_pulses", 32'(downPulses), 32'd0);
    checkOutput("flap_drop_count", 32'(ifMain.drop_count), 32'd0);
    checkOutput("flap_flap_count", 32'(ifMain.flap_count), expFlap);
    checkOutput("flap_up_cycles", ifMain.up_cycles, 32'd17);

    // clear_stats wins over the up_cycles increment of the same cycle
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_up_cycles", ifMain.up_cycles, 32'd0);
    checkOutput("clr_flap_count", 32'(ifMain.flap_count), 32'd0);
    checkOutput("clr_drop_count", 32'(ifMain.drop_count), 32'd0);
    stepCycle();
    checkOutput("clr_up_cycles_next", ifMain.up_cycles, 32'd1);

    // Five full drops (20 low / 20 high); clear at the 4th drop's falling edge
    upPulses = 0;
    downPulses = 0;
    for (int i = 0; i < 5; i++) begin
      expDrop    = (i < 3) ? 32'(i + 1) : ((i == 3) ? 32'd0 : 32'd1);
      expSatDrop = (i < 3) ? 32'(i + 1) : 32'd3;
      expUpLow   = (i == 3) ? 32'd0 : 32'd20;
      applyStimulus(1'b0, 1'b0);
      for (int s = 1; s <= 20; s++) begin
        stepCycle();
        if (s == 10 && i == 3) tbClear = 1'b1;
        if (s == 11) tbClear = 1'b0;
        countPulses();
        if (s == 10) checkOutput("drop_level_early", 32'(ifMain.channel_up), 32'd1);
        if (s == 11) begin
          checkOutput("drop_level", 32'(ifMain.channel_up), 32'd0);
          checkOutput("drop_pulse", 32'(ifMain.link_down_pulse), 32'd1);
          checkOutput("drop_count", 32'(ifMain.drop_count), expDrop);
          checkOutput("sat_drop_count", 32'(ifSat.drop_count), expSatDrop);
        end
        if (i > 0 && (s == 15 || s == 20))
          checkOutput("up_cycles_hold", ifMain.up_cycles, expUpLow);
      end
      applyStimulus(1'b1, 1'b0);
      for (int s = 1; s <= 20; s++) begin
        stepCycle();
        countPulses();
        if (s == 10) checkOutput("reup_level_early", 32'(ifMain.channel_up), 32'd0);
        if (s == 11) begin
          checkOutput("reup_level", 32'(ifMain.channel_up), 32'd1);
          checkOutput("reup_up_cycles", ifMain.up_cycles, 32'd0);
        end
        if (s == 20) checkOutput("reup_up_cycles_9", ifMain.up_cycles, 32'd9);
      end
    end
    checkOutput("drops_down_pulses", 32'(downPulses), 32'd5);
    checkOutput("drops_up_pulses", 32'(upPulses), 32'd5);
    checkOutput("drops_final_count", 32'(ifMain.drop_count), 32'd1);
    checkOutput("sat_final_count", 32'(ifSat.drop_count), 32'd3);
    checkOutput("drops_flap_count", 32'(ifMain.flap_count), 32'd0);

    // Reset in the middle of a down qualification, input then held high
    applyStimulus(1'b0, 1'b0);
    repeat (5) stepCycle();
    checkOutput("qual_down_level", 32'(ifMain.channel_up), 32'd1);
    applyStimulus(1'b1, 1'b0);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midrst_level", 32'(ifMain.channel_up), 32'd0);
    checkOutput("midrst_drop_count", 32'(ifMain.drop_count), 32'd0);
    checkOutput("midrst_up_cycles", ifMain.up_cycles, 32'd0);
    checkOutput("midrst_down_pulse", 32'(ifMain.link_down_pulse), 32'd0);
    repeat (2) stepCycle();
    rstN = 1'b1;
    upPulses = 0;
    downPulses = 0;
    for (int s = 1; s <= 11; s++) begin
      stepCycle();
      countPulses();
      if (s == 10) checkOutput("postrst_early", 32'(ifMain.channel_up), 32'd0);
      if (s == 11) begin
        checkOutput("postrst_level", 32'(ifMain.channel_up), 32'd1);
        checkOutput("postrst_up_pulse", 32'(ifMain.link_up_pulse), 32'd1);
      end
    end
    checkOutput("postrst_down_pulses", 32'(downPulses), 32'd0);
    checkOutput("postrst_up_pulses", 32'(upPulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/qsfp_link_monitor.md
Name: qsfp_link_monitor

Overview:
- Sits directly upstream of the Ethernet status register block: one instance per QSFP channel.
- Takes a raw, asynchronous "channel up" indication and synchronizes it into axi_clk.
- Debounces it into a stable channel_up level and produces link-event statistics for the status word.
- Outputs are register-ready: the status block samples them directly, with no further CDC.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal 2..4)
DEBOUNCE_CYCLES, 1000, cycles the synchronized input must hold a new level before it is accepted (legal >= 1)
CNT_W, 16, width of drop_count and flap_count

Ports:
axi_clk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
channel_up_async  in  1  raw channel-up from transceiver core, any clock domain
clear_stats  in  1  single-cycle pulse; clears drop_count, flap_count, up_cycles
channel_up  out  1  debounced link-up level
link_up_pulse  out  1  one-cycle pulse on accepted rising transition
link_down_pulse  out  1  one-cycle pulse on accepted falling transition
drop_count  out  CNT_W  saturating count of accepted up->down transitions
flap_count  out  CNT_W  saturating count of aborted qualifications (see Optional Feature)
up_cycles  out  32  cycles since last accepted link-up; saturating

Behaviour:
- Reset: axi_clk is the only clock; axi_resetn is asynchronous and active-low. While reset is low, all synchronizer flops, the FSM, the counters and every output are 0; the FSM is in DOWN.
- Synchronizer: SYNC_STAGES flop chain; its last stage is s_up. There is no other use of channel_up_async.
- FSM states and transitions (debounce counter dcnt, width clog2(DEBOUNCE_CYCLES+1)):
  - DOWN: if s_up=1, go to QUAL_UP and set dcnt=1.
  - QUAL_UP: if s_up=0, go to DOWN (aborted; flap event). Else if dcnt==DEBOUNCE_CYCLES, go to UP and assert link_up_pulse. Else dcnt++.
  - UP: if s_up=0, go to QUAL_DOWN and set dcnt=1.
  - QUAL_DOWN: if s_up=1, go to UP (aborted; flap event; no pulse). Else if dcnt==DEBOUNCE_CYCLES, go to DOWN, assert link_down_pulse and increment drop_count. Else dcnt++.
- channel_up = 1 in UP and QUAL_DOWN, registered.
- Latency: a clean edge on channel_up_async propagates to channel_up in SYNC_STAGES+DEBOUNCE_CYCLES cycles, +1 cycle of input-sampling uncertainty.
- Pulses: each pulse is high exactly one cycle, in the same cycle channel_up changes.
- up_cycles:
  - Loads 0 on the QUAL_UP->UP transition.
  - Increments every cycle while channel_up=1.
  - Holds its value while the link is down.
  - Saturates at 32'hFFFFFFFF.
- drop_count and flap_count saturate at all-ones and never wrap.
- clear_stats: the three statistics are 0 the next cycle. If an increment happens in the same cycle as clear_stats, the clear wins and the result is 0, not 1.
- Reset mid-qualification: the FSM returns to DOWN and no pulse is issued.
- DEBOUNCE_CYCLES=1: the qualifying state lasts exactly one cycle.

Optional Feature:
- Macro: QSFP_LINK_MON_FLAP_COUNT_EN.
- Defined: flap_count increments on every aborted qualification, i.e. QUAL_UP->DOWN or QUAL_DOWN->UP.
- Undefined: flap_count is tied to 0 and its counter logic is not synthesized. The port list is identical in both builds.

Decomposition:
- Package qsfp_mon_pkg:
  - FSM state enum: DOWN, QUAL_UP, UP, QUAL_DOWN.
  - UP_CYCLES_W=32.
  - Saturating-increment helper function.
- One sub-module, link_mon_sync: parameterized SYNC_STAGES flop chain with asynchronous active-low reset and ASYNC_REG attribute.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, CNT_W=16 unless noted):
- Reset asserted mid-operation, with input held high -> all outputs 0 immediately; after release, channel_up rises 10 cycles after s_up input edge sampling.
- channel_up_async rises and stays high -> channel_up=1 at cycle 10 after the sampling edge; link_up_pulse high exactly that cycle; up_cycles=0 then counts 1,2,3...
- From UP, input low for 5 cycles then high -> channel_up stays 1, no pulses, drop_count=0; flap_count=1 with macro, 0 without.
- Three full drops (low 20 cycles, high 20 cycles) -> three link_down_pulse, drop_count=3, up_cycles held while down and reloaded to 0 on each up.
- CNT_W=2 with 5 drops -> drop_count=3 (saturated).
- clear_stats asserted in the same cycle as the QUAL_DOWN->DOWN transition -> drop_count=0 next cycle, link_down_pulse still issued.
